// File: rtl/am2940_pkg.sv
// am2940_pkg: shared mode and state types for the AM2940 transfer sequencer
package am2940_pkg;
  typedef enum logic [1:0] {
    MODE_WC_DOWN  = 2'b00,
    MODE_WC_CMP   = 2'b01,
    MODE_ADDR_CMP = 2'b10,
    MODE_NONSTOP  = 2'b11
  } xfer_mode_e;
  typedef enum logic [1:0] {IDLE, XFER, FIN} seq_state_e;
endpackage

// File: rtl/am2940_last_detect.sv
// am2940_last_detect: combinational last-transfer decode on pre-step counter values
module am2940_last_detect
  import am2940_pkg::*;
#(
  parameter int W = 8
) (
  input  xfer_mode_e     mode,
  input  logic [W-1:0]   wco,
  input  logic [W-1:0]   wreg,
  input  logic [W-1:0]   aco,
  input  logic [W-1:0]   addr_stop,
  output logic           last
);
  logic [W-1:0] wco_inc;
  assign wco_inc = wco + W'(1);
  always_comb
    last = mode == MODE_WC_DOWN  ? wco == W'(1) :
           mode == MODE_WC_CMP   ? wco_inc == wreg :
           mode == MODE_ADDR_CMP ? aco == addr_stop : 1'b0;
endmodule

// File: rtl/am2940_xfer_seq.sv
// am2940_xfer_seq: DMA block sequencer stepping address/word counters per bus handshake
module am2940_xfer_seq
  import am2940_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic           addr_dec,
  input  logic [W-1:0]   addr_init,
  input  logic [W-1:0]   wc_init,
  input  logic [W-1:0]   wreg,
  input  logic [W-1:0]   addr_stop,
  input  logic           bus_ack,
  output logic           bus_req,
  output logic [W-1:0]   aco,
  output logic [W-1:0]   wco,
  output logic           busy,
  output logic           done,
  output logic           aborted
);
  seq_state_e state;
  xfer_mode_e mode_q;
  logic       dec_q;
  logic       last;
  am2940_last_detect #(.W(W)) u_last (
    .mode(mode_q),
    .wco(wco),
    .wreg(wreg),
    .aco(aco),
    .addr_stop(addr_stop),
    .last(last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      mode_q  <= MODE_WC_DOWN;
      dec_q   <= 1'b0;
      aco     <= '0;
      wco     <= '0;
      bus_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= XFER;
          mode_q  <= xfer_mode_e'(mode);
          dec_q   <= addr_dec;
          aco     <= addr_init;
          wco     <= xfer_mode_e'(mode) == MODE_WC_DOWN ? wc_init : '0;
          bus_req <= 1'b1;
          busy    <= 1'b1;
        end
        XFER: if (abort) begin
          state   <= IDLE;
          bus_req <= 1'b0;
          busy    <= 1'b0;
          aborted <= 1'b1;
        end else if (bus_ack) begin
          aco <= dec_q ? aco - W'(1) : aco + W'(1);
          wco <= mode_q == MODE_WC_DOWN ? wco - W'(1) : wco + W'(1);
          if (last) begin
            state   <= FIN;
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_am2940_xfer_seq.sv
// tb_am2940_xfer_seq: directed and randomized block transfers checked against a transfer-count model
module tb_am2940_xfer_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       addr_dec = 1'b0;
  logic [7:0] addr_init = '0;
  logic [7:0] wc_init = '0;
  logic [7:0] wreg = '0;
  logic [7:0] addr_stop = '0;
  logic       bus_ack = 1'b0;
  logic       bus_req;
  logic [7:0] aco;
  logic [7:0] wco;
  logic       busy;
  logic       done;
  logic       aborted;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  am2940_xfer_seq #(.W(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .mode(mode),
    .addr_dec(addr_dec),
    .addr_init(addr_init),
    .wc_init(wc_init),
    .wreg(wreg),
    .addr_stop(addr_stop),
    .bus_ack(bus_ack),
    .bus_req(bus_req),
    .aco(aco),
    .wco(wco),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_regs(input string tag, input logic [7:0] ea, input logic [7:0] ew);
    chk({tag, "_req"}, bus_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_aco"}, aco, ea);
    chk({tag, "_wco"}, wco, ew);
  endtask
  // ack_pct < 0 acks every other cycle; abort_after >= 0 aborts together with that ack
  task automatic run_block(input logic [1:0] m, input logic d, input logic [7:0] ai, input logic [7:0] wc,
                           input logic [7:0] wr, input logic [7:0] as, input int ack_pct,
                           input int abort_after, input bit start_mid);
    int n_exp;
    int n = 0;
    int cyc = 0;
    bit fin = 0;
    bit ack;
    bit ab;
    logic [7:0] ea;
    logic [7:0] ew;
    case (m)
      2'b00: n_exp = wc == 0 ? 256 : int'(wc);
      2'b01: n_exp = wr == 0 ? 256 : int'(wr);
      2'b10: n_exp = int'(d ? 8'(ai - as) : 8'(as - ai)) + 1;
      default: n_exp = -1;
    endcase
    @(negedge clk);
    mode = m; addr_dec = d; addr_init = ai; wc_init = wc; wreg = wr; addr_stop = as; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_req", bus_req, 1);
    chk("load_busy", busy, 1);
    chk("load_aco", aco, ai);
    chk("load_wco", wco, m == 2'b00 ? wc : 8'h00);
    while (!fin && cyc < 5000) begin
      ab = abort_after >= 0 && n == abort_after;
      ack = ab ? 1'b1 : (ack_pct < 0 ? cyc[0] : $urandom_range(99) < ack_pct);
      bus_ack = ack;
      abort = ab;
      if (start_mid && cyc == 5) begin start = 1'b1; addr_init = ~ai; end
      @(negedge clk);
      cyc++;
      bus_ack = 1'b0; abort = 1'b0; start = 1'b0; addr_init = ai;
      if (!ab && ack) n++;
      ea = d ? ai - 8'(n) : ai + 8'(n);
      ew = m == 2'b00 ? wc - 8'(n) : 8'(n);
      chk("step_aco", aco, ea);
      chk("step_wco", wco, ew);
      if (ab) begin
        fin = 1;
        chk("abort_pulse", aborted, 1);
        chk("abort_done", done, 0);
        chk_idle_regs("abort", ea, ew);
      end else if (n == n_exp) begin
        fin = 1;
        chk("done_pulse", done, 1);
        chk_idle_regs("fin", ea, ew);
      end else begin
        chk("run_done", done, 0);
        chk("run_aborted", aborted, 0);
        chk("run_req", bus_req, 1);
        chk("run_busy", busy, 1);
      end
    end
    chk("block_finished", fin, 1);
    ea = d ? ai - 8'(n) : ai + 8'(n);
    ew = m == 2'b00 ? wc - 8'(n) : 8'(n);
    bus_ack = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    abort = 1'b0;
    chk("after_done", done, 0);
    chk("after_aborted", aborted, 0);
    chk_idle_regs("after", ea, ew);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_aco", aco, 0);
    chk("rst_wco", wco, 0);
    rst = 1'b0;
    bus_ack = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    abort = 1'b0;
    chk("idle_ack_aco", aco, 0);
    chk("idle_abort", aborted, 0);
    run_block(2'b00, 1'b0, 8'd10, 8'd3, 8'd0, 8'd0, 100, -1, 0);
    run_block(2'b01, 1'b1, 8'd2, 8'd0, 8'd4, 8'd0, -1, -1, 0);
    run_block(2'b10, 1'b0, 8'hF0, 8'd0, 8'd0, 8'hF3, 100, -1, 0);
    run_block(2'b11, 1'b0, 8'h00, 8'd0, 8'd0, 8'd0, 100, 300, 0);
    run_block(2'b00, 1'b0, 8'h55, 8'd0, 8'd0, 8'd0, 100, -1, 1);
    run_block(2'b01, 1'b0, 8'h20, 8'd0, 8'd1, 8'd0, 70, -1, 0);
    run_block(2'b01, 1'b0, 8'h30, 8'd0, 8'd0, 8'd0, 100, -1, 0);
    run_block(2'b10, 1'b1, 8'h07, 8'd0, 8'd0, 8'h07, 50, -1, 0);
    run_block(2'b10, 1'b1, 8'h01, 8'd0, 8'd0, 8'hFE, 100, -1, 0);
    @(negedge clk);
    mode = 2'b00; addr_dec = 1'b0; addr_init = 8'h40; wc_init = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_done", done, 0);
    chk("midrst_aborted", aborted, 0);
    chk_idle_regs("midrst", 8'h00, 8'h00);
    run_block(2'b00, 1'b1, 8'h02, 8'd5, 8'd0, 8'd0, 60, -1, 0);
    for (int i = 0; i < 20; i++) begin
      logic [1:0] m;
      logic [7:0] wc;
      logic [7:0] wr;
      int na;
      m = 2'($urandom_range(3));
      wc = 8'($urandom);
      wr = 8'($urandom);
      na = -1;
      if (m == 2'b11) na = $urandom_range(60);
      else if ($urandom_range(3) == 0) na = $urandom_range(m == 2'b00 ? (wc == 0 ? 255 : int'(wc) - 1) : 0);
      run_block(m, 1'($urandom), 8'($urandom), wc, wr, 8'($urandom), 30 + $urandom_range(70), na, 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
